// File: rtl/slr_pkg.sv
// Shared constants and helpers for the shift_load_reg slice.
package slr_pkg;

  localparam int SLR_DEFAULT_WIDTH = 8;

  // Bits needed to count from 0 up to and including w.
  function automatic int slr_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_load_reg_if.sv
// Control/data bundle of the shift_load_reg; done exists only with SHIFTLOADREG_BITCNT_EN.
// Handshake: no valid/ready; load and en are single-cycle strobes sampled on each rising clk edge.
interface shift_load_reg_if
  import slr_pkg::*;
#(
  parameter int WIDTH = SLR_DEFAULT_WIDTH
);
  logic             load;
  logic             en;
  logic             in;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             out;
`ifdef SHIFTLOADREG_BITCNT_EN
  logic             done;

  modport master (output load, en, in, D, input Q, out, done);
  modport slave  (input load, en, in, D, output Q, out, done);
`else
  modport master (output load, en, in, D, input Q, out);
  modport slave  (input load, en, in, D, output Q, out);
`endif
endinterface

// File: rtl/slr_bit_counter.sv
// Saturating shift counter; done is a registered level once WIDTH shifts have occurred since load.
module slr_bit_counter
  import slr_pkg::*;
#(
  parameter int WIDTH = SLR_DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);
  localparam int CNT_W = slr_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // done is computed from the post-shift count so it rises on the WIDTH-th shift edge.
  always_comb begin
    cnt_next = cnt;
    if (cnt != CNT_MAX) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (load) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (en) begin
      cnt  <= cnt_next;
      done <= (cnt_next == CNT_MAX);
    end
  end
endmodule

// File: rtl/shift_load_reg.sv
// Parallel-load / serial-shift register for an SPI shift buffer.
// Optional bit counter and done flag enabled by defining SHIFTLOADREG_BITCNT_EN.
module shift_load_reg
  import slr_pkg::*;
#(
  parameter int WIDTH     = SLR_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               rst,
  shift_load_reg_if.slave   bus
);
  logic [WIDTH-1:0] q;

  // Load has priority over shift; X on in is deliberately passed through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (bus.load) begin
      q <= bus.D;
    end else if (bus.en) begin
      if (MSB_FIRST) begin
        q <= {q[WIDTH-2:0], bus.in};
      end else begin
        q <= {bus.in, q[WIDTH-1:1]};
      end
    end
  end

  assign bus.Q   = q;
  assign bus.out = MSB_FIRST ? q[WIDTH-1] : q[0];

`ifdef SHIFTLOADREG_BITCNT_EN
  slr_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .load (bus.load),
    .en   (bus.en),
    .done (bus.done)
  );
`endif
endmodule

// File: tb/tb_shift_load_reg.sv
// Self-checking bench for shift_load_reg: MSB-first instance a, LSB-first instance b.
module tb_shift_load_reg;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [W-1:0] model_a;
  logic [W-1:0] model_b;

  shift_load_reg_if #(.WIDTH(W)) bus_a ();
  shift_load_reg_if #(.WIDTH(W)) bus_b ();

  shift_load_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  shift_load_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- drivers ----------------
  task automatic drive_a(input logic l, input logic e, input logic i, input logic [W-1:0] d);
    @(negedge clk);
    bus_a.load = l;
    bus_a.en   = e;
    bus_a.in   = i;
    bus_a.D    = d;
    if (l)      model_a = d;
    else if (e) model_a = {model_a[W-2:0], i};
    exp_q.push_back(model_a);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic l, input logic e, input logic i, input logic [W-1:0] d);
    @(negedge clk);
    bus_b.load = l;
    bus_b.en   = e;
    bus_b.in   = i;
    bus_b.D    = d;
    if (l)      model_b = d;
    else if (e) model_b = {i, model_b[W-1:1]};
    exp_b_q.push_back(model_b);
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] exp;
    checks++;
    if (bus_a.Q !== 8'h00 || bus_b.Q !== 8'h00) begin
      errors++;
      $display("FAIL reset_initial: Q_a=%h Q_b=%h expected 00", bus_a.Q, bus_b.Q);
    end
    @(negedge clk);
    rst = 1'b1;
    drive_a(1'b1, 1'b0, 1'b0, 8'hAA);
    exp = exp_q.pop_front();
    checks++;
    if (bus_a.Q !== exp) begin
      errors++;
      $display("FAIL reset_preload: Q=%h expected %h", bus_a.Q, exp);
    end
    // Assert reset between edges with load pending: must clear at once.
    @(negedge clk);
    #2;
    bus_a.D    = 8'hFF;
    bus_a.load = 1'b1;
    rst        = 1'b0;
    model_a    = '0;
    model_b    = '0;
    #1;
    checks++;
    if (bus_a.Q !== 8'h00 || bus_a.out !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: Q=%h out=%b expected 00/0", bus_a.Q, bus_a.out);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus_a.Q !== 8'h00 || bus_b.Q !== 8'h00) begin
      errors++;
      $display("FAIL reset_held: Q_a=%h Q_b=%h expected 00", bus_a.Q, bus_b.Q);
    end
`ifdef SHIFTLOADREG_BITCNT_EN
    checks++;
    if (bus_a.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: done=%b expected 0", bus_a.done);
    end
`endif
    @(negedge clk);
    bus_a.load = 1'b0;
    rst        = 1'b1;
    drive_a(1'b0, 1'b0, 1'b0, 8'h00);
    exp = exp_q.pop_front();
    checks++;
    if (bus_a.Q !== exp) begin
      errors++;
      $display("FAIL reset_release_hold: Q=%h expected %h", bus_a.Q, exp);
    end
  endtask

  task automatic test_load_shift();
    logic [W-1:0] exp;
    logic [W-1:0] seq [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
    for (int k = 0; k < 9; k++) begin
      if (k == 0) drive_a(1'b1, 1'b0, 1'b0, 8'h01);
      else        drive_a(1'b0, 1'b1, 1'b0, 8'h00);
      exp = exp_q.pop_front();
      checks++;
      if (bus_a.Q !== exp || bus_a.Q !== seq[k]) begin
        errors++;
        $display("FAIL load_shift_q[%0d]: Q=%h expected %h", k, bus_a.Q, seq[k]);
      end
      checks++;
      if (bus_a.out !== (seq[k] == 8'h80)) begin
        errors++;
        $display("FAIL load_shift_out[%0d]: out=%b expected %b", k, bus_a.out, seq[k] == 8'h80);
      end
    end
  endtask

  task automatic test_serial_receive();
    logic [W-1:0] exp;
    logic [W-1:0] rx_bits = 8'b1011_0010;
    logic [W-1:0] emitted;
    emitted = '0;
    drive_a(1'b1, 1'b0, 1'b0, 8'hA5);
    exp = exp_q.pop_front();
    checks++;
    if (bus_a.Q !== exp) begin
      errors++;
      $display("FAIL rx_load: Q=%h expected %h", bus_a.Q, exp);
    end
    for (int k = 0; k < W; k++) begin
      emitted = {emitted[W-2:0], bus_a.out};
      drive_a(1'b0, 1'b1, rx_bits[W-1-k], 8'h00);
      exp = exp_q.pop_front();
      checks++;
      if (bus_a.Q !== exp) begin
        errors++;
        $display("FAIL rx_shift[%0d]: Q=%h expected %h", k, bus_a.Q, exp);
      end
    end
    checks++;
    if (bus_a.Q !== 8'hB2) begin
      errors++;
      $display("FAIL rx_word: Q=%h expected b2", bus_a.Q);
    end
    checks++;
    if (emitted !== 8'hA5) begin
      errors++;
      $display("FAIL tx_stream: out bits=%h expected a5", emitted);
    end
  endtask

  task automatic test_priority_hold();
    logic [W-1:0] exp;
    drive_a(1'b1, 1'b1, 1'b1, 8'h3C);
    exp = exp_q.pop_front();
    checks++;
    if (bus_a.Q !== exp || bus_a.Q !== 8'h3C) begin
      errors++;
      $display("FAIL load_over_en: Q=%h expected 3c", bus_a.Q);
    end
    drive_a(1'b0, 1'b0, 1'b1, 8'hFF);
    exp = exp_q.pop_front();
    checks++;
    if (bus_a.Q !== exp || bus_a.Q !== 8'h3C) begin
      errors++;
      $display("FAIL hold: Q=%h expected 3c", bus_a.Q);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    drive_a(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
    for (int k = 0; k < 20; k++) begin
      drive_a(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'h00);
    end
    for (int k = 0; k < 21; k++) begin
      exp = exp_q.pop_front();
      if (k == 20) begin
        checks++;
        if (bus_a.Q !== exp || bus_a.out !== exp[W-1]) begin
          errors++;
          $display("FAIL back_to_back: Q=%h out=%b expected %h/%b", bus_a.Q, bus_a.out, exp, exp[W-1]);
        end
      end
    end
  endtask

  task automatic test_back_to_back_stepwise();
    logic [W-1:0] exp;
    for (int k = 0; k < 12; k++) begin
      drive_a(1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'h00);
      exp = exp_q.pop_front();
      checks++;
      if (bus_a.Q !== exp) begin
        errors++;
        $display("FAIL overshift[%0d]: Q=%h expected %h", k, bus_a.Q, exp);
      end
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] exp;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) drive_b(1'b1, 1'b0, 1'b0, 8'h80);
      else        drive_b(1'b0, 1'b1, 1'b0, 8'h00);
      exp = exp_b_q.pop_front();
      checks++;
      if (bus_b.Q !== exp || bus_b.out !== exp[0]) begin
        errors++;
        $display("FAIL lsb_shift[%0d]: Q=%h out=%b expected %h/%b", k, bus_b.Q, bus_b.out, exp, exp[0]);
      end
    end
    checks++;
    if (bus_b.Q !== 8'h01 || bus_b.out !== 1'b1) begin
      errors++;
      $display("FAIL lsb_final: Q=%h out=%b expected 01/1", bus_b.Q, bus_b.out);
    end
  endtask

`ifdef SHIFTLOADREG_BITCNT_EN
  task automatic test_bitcnt();
    logic [W-1:0] exp;
    drive_a(1'b1, 1'b0, 1'b0, 8'h5A);
    exp = exp_q.pop_front();
    for (int k = 1; k <= 9; k++) begin
      drive_a(1'b0, 1'b1, 1'b1, 8'h00);
      exp = exp_q.pop_front();
      checks++;
      if (bus_a.done !== (k >= W) || bus_a.Q !== exp) begin
        errors++;
        $display("FAIL done_shift[%0d]: done=%b Q=%h expected %b/%h", k, bus_a.done, bus_a.Q, k >= W, exp);
      end
    end
    drive_a(1'b1, 1'b0, 1'b0, 8'h00);
    exp = exp_q.pop_front();
    checks++;
    if (bus_a.done !== 1'b0) begin
      errors++;
      $display("FAIL done_reload: done=%b expected 0", bus_a.done);
    end
  endtask
`endif

  // ---------------- main sequence + report ----------------
  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    model_a    = '0;
    model_b    = '0;
    bus_a.load = 1'b0; bus_a.en = 1'b0; bus_a.in = 1'b0; bus_a.D = '0;
    bus_b.load = 1'b0; bus_b.en = 1'b0; bus_b.in = 1'b0; bus_b.D = '0;
    #1;
    test_reset();
    test_load_shift();
    test_serial_receive();
    test_priority_hold();
    test_back_to_back();
    test_back_to_back_stepwise();
    test_lsb_first();
`ifdef SHIFTLOADREG_BITCNT_EN
    test_bitcnt();
`endif
    checks++;
    if (exp_q.size() != 0 || exp_b_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left a=%0d b=%0d expected 0/0", exp_q.size(), exp_b_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shift_load_reg.md
Name: shift_load_reg

Overview:
- Parallel-load / serial-shift register: the core of an SPI shift buffer.
- Loads a transmit word in parallel, then shifts one bit per enabled clock.
- Serial data enters at one end and leaves at the other, so after WIDTH shifts Q holds the received word.
- Sits between the SPI clock domain logic and the tx/rx packet interfaces.

Parameters:
- WIDTH, 8, register width in bits; must be >= 2.
- MSB_FIRST, 1, shift direction. 1: shift toward MSB, serial in at bit 0, serial out = Q[WIDTH-1]. 0: shift toward LSB, serial in at bit WIDTH-1, serial out = Q[0].

Ports:
- clk  input  1  shift clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- load  input  1  parallel load strobe, synchronous.
- en  input  1  shift enable, synchronous.
- in  input  1  serial data in.
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  register contents; received word after WIDTH shifts.
- out  output  1  serial data out (combinational from Q, per MSB_FIRST).

Behaviour:
- One clock domain. Reset is asynchronous and active-low (port rst): asserting rst low immediately forces Q = 0, so out = 0. Release is synchronous to the next clk edge.
- Each rising clk edge, priority order:
  - load = 1: Q <= D. Load wins over en when both are high; no shift occurs that cycle.
  - else en = 1 with MSB_FIRST = 1: Q <= {Q[WIDTH-2:0], in}.
  - else en = 1 with MSB_FIRST = 0: Q <= {in, Q[WIDTH-1:1]}.
  - else: Q holds.
- Latency: Q reflects load or shift one edge after the sampling edge. out follows Q combinationally, with no extra register.
- The shift count is not limited. Shifting beyond WIDTH continues to push in bits; the oldest bits are discarded.
- Reset asserted mid-operation aborts the transfer; Q = 0 until the first load or shift after release.
- X on in while en = 1 propagates into Q. No masking is performed.

Optional Feature:
- Macro SHIFTLOADREG_BITCNT_EN.
- When defined, adds output done (1 bit) and an internal counter cnt of $clog2(WIDTH+1) bits.
- cnt reset value is 0. Reset clears cnt and done.
- load: cnt <= 0, done <= 0.
- Shift (en without load): cnt increments, saturating at WIDTH.
- done = (cnt == WIDTH), registered level; it stays high until the next load or reset.
- When not defined: no done port, no counter; the rest of the behaviour is identical.

Decomposition:
- Package slr_pkg: constant SLR_DEFAULT_WIDTH = 8 and localparam helper for the counter width.
- One sub-module, slr_bit_counter: the saturating counter plus done generation. Instantiated only under SHIFTLOADREG_BITCNT_EN.
- Data path stays in the top module.

Test Plan:
- Reset: rst = 0 with D = 8'hFF, load = 1 -> Q = 8'h00 immediately (async), out = 0; remains 0 while rst = 0 regardless of clk.
- Load then shift zeros (MSB_FIRST = 1): D = 8'h01, load for one edge, then en = 1, in = 0 for 8 edges -> Q = 01, 02, 04, 08, 10, 20, 40, 80, 00. out = 1 only while Q = 8'h80.
- Serial receive: load D = 8'hA5, then shift in = 1,0,1,1,0,0,1,0 on 8 edges -> Q = 8'hB2. out emits 1,0,1,0,0,1,0,1 (A5 MSB first).
- Priority/hold: load = 1 and en = 1 together with D = 8'h3C -> Q = 8'h3C, no shift. Next edge with load = 0, en = 0 -> Q holds 8'h3C.
- MSB_FIRST = 0: load 8'h80, shift in = 0 for 7 edges -> Q = 8'h01, out = 1.
- With SHIFTLOADREG_BITCNT_EN: load, 7 shifts -> done = 0; 8th shift -> done = 1; 9th shift -> done stays 1; load -> done = 0.
